// File: rtl/pipe_reg_gen.sv
// Parameterised pipeline register chain with stall/bubble/flush handling,
// valid tracking, registered occupancy and a saturating bubble counter.
module pipe_reg_gen #(
  parameter int DATA_W = 106,
  parameter int DEPTH  = 1,
  parameter int STAGE  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        stall,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [2:0]        occupancy,
  output logic [15:0]       bubble_cnt
);

  typedef enum logic [1:0] {
    ACT_HOLD    = 2'd0,
    ACT_FLUSH   = 2'd1,
    ACT_BUBBLE  = 2'd2,
    ACT_ADVANCE = 2'd3
  } act_e;

  localparam logic [DATA_W-1:0] ZERO_DATA = {DATA_W{1'b0}};

  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];
  logic [2:0]        occ_q, occ_d;
  logic [15:0]       bubble_cnt_q, bubble_cnt_d;
  logic              up_s, dn_s;
  act_e              act_s;
  logic              stall_unused_s;

  function automatic logic [2:0] popcount(input logic [DEPTH-1:0] v);
    logic [2:0] c;
    c = 3'd0;
    for (int i = 0; i < DEPTH; i++) begin
      c = c + {2'b00, v[i]};
    end
    return c;
  endfunction

  assign up_s           = stall[STAGE];
  assign dn_s           = stall[STAGE+1];
  // Only this stage's two stall bits matter; the rest are deliberately ignored.
  assign stall_unused_s = ^stall;

  // Per-cycle action select; flush outranks every stall combination.
  always_comb begin
    act_s = ACT_HOLD;
    if (flush) begin
      act_s = ACT_FLUSH;
    end else if (up_s && !dn_s) begin
      act_s = ACT_BUBBLE;
    end else if (!up_s) begin
      act_s = ACT_ADVANCE;
    end else begin
      act_s = ACT_HOLD;
    end
  end

  // Next-state for the chain, occupancy and bubble counter.
  always_comb begin
    valid_d      = valid_q;
    data_d       = data_q;
    bubble_cnt_d = bubble_cnt_q;
    case (act_s)
      ACT_FLUSH: begin
        for (int i = 0; i < DEPTH; i++) begin
          valid_d[i] = 1'b0;
          data_d[i]  = ZERO_DATA;
        end
      end
      ACT_BUBBLE: begin
        for (int i = 1; i < DEPTH; i++) begin
          valid_d[i] = valid_q[i-1];
          data_d[i]  = data_q[i-1];
        end
        valid_d[0] = 1'b0;
        data_d[0]  = ZERO_DATA;
        if (bubble_cnt_q != 16'hFFFF) begin
          bubble_cnt_d = bubble_cnt_q + 16'd1;
        end else begin
          bubble_cnt_d = bubble_cnt_q;
        end
      end
      ACT_ADVANCE: begin
        for (int i = 1; i < DEPTH; i++) begin
          valid_d[i] = valid_q[i-1];
          data_d[i]  = data_q[i-1];
        end
        valid_d[0] = in_valid;
        // Invalid entries are zeroed so no stale payload travels down the chain.
        data_d[0]  = in_valid ? in_data : ZERO_DATA;
      end
      default: begin
        valid_d = valid_q;
      end
    endcase
    occ_d = popcount(valid_d);
  end

  // State registers with synchronous reset overriding flush and stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q      <= {DEPTH{1'b0}};
      occ_q        <= 3'd0;
      bubble_cnt_q <= 16'd0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= ZERO_DATA;
      end
    end else begin
      valid_q      <= valid_d;
      occ_q        <= occ_d;
      bubble_cnt_q <= bubble_cnt_d;
      data_q       <= data_d;
    end
  end

  assign out_valid  = valid_q[DEPTH-1];
  assign out_data   = data_q[DEPTH-1];
  assign occupancy  = occ_q;
  assign bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_pipe_reg_gen.sv
// Scoreboard bench for pipe_reg_gen: a queue-based reference chain predicts
// each edge's outputs; a monitor pops and compares after every edge.
module tb_pipe_reg_gen;
  localparam int DW    = 106;
  localparam int DEPTH = 3;
  localparam int STAGE = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [5:0]    stall = 6'd0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = {DW{1'b0}};
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [2:0]    occupancy;
  logic [15:0]   bubble_cnt;

  pipe_reg_gen #(.DATA_W(DW), .DEPTH(DEPTH), .STAGE(STAGE)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .out_data(out_data),
    .occupancy(occupancy), .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          v;
    logic [DW-1:0] d;
  } ent_t;

  typedef struct packed {
    logic          v;
    logic [DW-1:0] d;
    logic [2:0]    occ;
    logic [15:0]   bc;
  } exp_t;

  ent_t pipe[$];
  exp_t sb[$];
  int   bcnt = 0;
  int   n_vec = 0;
  int   n_bad = 0;
  bit   done = 1'b0;

  task automatic compare(input string name, input logic [127:0] act, input logic [127:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  function automatic logic [DW-1:0] rand_data();
    logic [127:0] w;
    w = {$urandom, $urandom, $urandom, $urandom};
    return w[DW-1:0];
  endfunction

  // Apply one cycle of stimulus and predict the post-edge state.
  task automatic step(input logic r, input logic f, input logic [5:0] st,
                      input logic iv, input logic [DW-1:0] id);
    exp_t e;
    ent_t z;
    ent_t n;
    int   cnt;
    @(negedge clk);
    rst = r; flush = f; stall = st; in_valid = iv; in_data = id;
    z = '{v: 1'b0, d: {DW{1'b0}}};
    if (r || f) begin
      pipe.delete();
      for (int i = 0; i < DEPTH; i++) pipe.push_back(z);
      if (r) bcnt = 0;
    end else if (st[STAGE] && !st[STAGE+1]) begin
      pipe.push_front(z);
      void'(pipe.pop_back());
      bcnt = (bcnt >= 65535) ? 65535 : bcnt + 1;
    end else if (!st[STAGE]) begin
      n.v = iv;
      n.d = iv ? id : {DW{1'b0}};
      pipe.push_front(n);
      void'(pipe.pop_back());
    end
    cnt = 0;
    foreach (pipe[i]) if (pipe[i].v) cnt++;
    e.v   = pipe[DEPTH-1].v;
    e.d   = pipe[DEPTH-1].d;
    e.occ = cnt[2:0];
    e.bc  = bcnt[15:0];
    sb.push_back(e);
  endtask

  // Monitor: the DUT presents a new result after every rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        compare("out_valid", {127'd0, out_valid}, {127'd0, e.v});
        compare("out_data", {22'd0, out_data}, {22'd0, e.d});
        compare("occupancy", {125'd0, occupancy}, {125'd0, e.occ});
        compare("bubble_cnt", {112'd0, bubble_cnt}, {112'd0, e.bc});
      end
    end
  end

  logic [DW-1:0] a_d, b_d, c_d;

  initial begin
    for (int i = 0; i < DEPTH; i++) pipe.push_back('{v: 1'b0, d: {DW{1'b0}}});
    a_d = rand_data(); b_d = rand_data(); c_d = rand_data();

    // reset overrides flush/stall and random inputs
    step(1'b1, 1'b1, 6'b110000, 1'b1, a_d);
    step(1'b1, 1'b0, 6'b010000, 1'b1, b_d);
    // A, B, C on consecutive advance edges, then drain with don't-care stall bits
    step(1'b0, 1'b0, 6'b000000, 1'b1, a_d);
    step(1'b0, 1'b0, 6'b001111, 1'b1, b_d);
    step(1'b0, 1'b0, 6'b100000, 1'b1, c_d);
    @(posedge clk); #2;
    compare("abc_out_a", {22'd0, out_data}, {22'd0, a_d});
    compare("abc_occ3", {125'd0, occupancy}, 128'd3);
    step(1'b0, 1'b0, 6'b000000, 1'b0, 106'h2A);
    @(posedge clk); #2;
    compare("abc_out_b", {22'd0, out_data}, {22'd0, b_d});
    // full chain then bubbles
    step(1'b0, 1'b0, 6'b000000, 1'b1, 106'h2A);
    step(1'b0, 1'b0, 6'b000000, 1'b1, rand_data());
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 6'b010000, 1'b1, rand_data());
    @(posedge clk); #2;
    compare("bubble_cnt3", {112'd0, bubble_cnt}, 128'd3);
    compare("bubble_empty", {125'd0, occupancy}, 128'd0);
    // refill then hold 5 cycles, then release
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 6'b000000, 1'b1, rand_data());
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 6'b110000, 1'b1, rand_data());
    for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 6'b000000, 1'b1, rand_data());
    // flush together with hold; bubble_cnt kept
    step(1'b0, 1'b1, 6'b110000, 1'b1, rand_data());
    @(posedge clk); #2;
    compare("flush_occ", {125'd0, occupancy}, 128'd0);
    compare("flush_bc", {112'd0, bubble_cnt}, 128'd3);
    // randomized traffic
    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 19) == 0),
           6'($urandom), 1'($urandom), rand_data());
    // reset in the middle of a hold sequence
    step(1'b0, 1'b0, 6'b000000, 1'b1, rand_data());
    step(1'b0, 1'b0, 6'b110000, 1'b1, rand_data());
    step(1'b1, 1'b0, 6'b110000, 1'b1, rand_data());
    // drive counter to saturation
    while (bcnt < 65534) step(1'b0, 1'b0, 6'b010000, 1'b1, rand_data());
    @(posedge clk); #2;
    compare("bc_fffe", {112'd0, bubble_cnt}, 128'hFFFE);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 6'b011010, 1'b0, rand_data());
    @(posedge clk); #2;
    compare("bc_sat", {112'd0, bubble_cnt}, 128'hFFFF);
    step(1'b1, 1'b0, 6'b010000, 1'b1, rand_data());
    @(posedge clk); #2;
    compare("bc_rst", {112'd0, bubble_cnt}, 128'd0);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    #3;
    if (sb.size() > 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain: %0d entries pending, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
